// File: rtl/booth_divider_datapath_if.sv
// ============================================================================
// Module  : booth_divider_datapath_if
// Purpose : Request/result bundle between a requester and the iterative divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_divider_datapath_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/booth_divider_datapath.sv
// ============================================================================
// Module  : booth_divider_datapath
// Purpose : Iterative restoring divider, one quotient bit per clock, WIDTH+2
//           cycle latency. Define SIGNED_DIV_EN for two's-complement operands.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_divider_datapath #(
  parameter int WIDTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  booth_divider_datapath_if.slave bus
);

  localparam int                c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0]   c_INC  = c_CW'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_dividend;
  logic [c_CW-1:0]  r_iter;
  logic             r_dbz;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dbz_out;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_div_zero;

  assign w_div_zero = (bus.divisor == '0);

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;

  // Magnitudes as unsigned WIDTH-bit values; the most-negative code maps to itself.
  assign w_mag_a = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_mag_b = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;
`else
  assign w_mag_a = bus.dividend;
  assign w_mag_b = bus.divisor;
  assign w_q_fix = r_quo;
  assign w_r_fix = r_rem;
`endif

  // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial sign.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};
  assign w_ge    = ~w_trial[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_dividend <= '0;
      r_iter     <= '0;
      r_dbz      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q_out    <= '0;
      r_r_out    <= '0;
      r_dbz_out  <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_quo      <= w_mag_a;
            r_div      <= w_mag_b;
            r_dividend <= bus.dividend;
            r_rem      <= '0;
            r_iter     <= '0;
            r_dbz      <= w_div_zero;
            r_busy     <= 1'b1;
            r_dbz_out  <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r    <= bus.dividend[WIDTH-1];
`endif
            r_state    <= w_div_zero ? c_FIX : c_CALC;
          end
        end
        c_CALC: begin
          r_rem  <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo  <= {r_quo[WIDTH-2:0], w_ge};
          r_iter <= r_iter + c_INC;
          if (r_iter == c_LAST) begin
            r_state <= c_FIX;
          end
        end
        c_FIX: begin
          if (r_dbz) begin
            r_q_out   <= '1;
            r_r_out   <= r_dividend;
            r_dbz_out <= 1'b1;
          end else begin
            r_q_out   <= w_q_fix;
            r_r_out   <= w_r_fix;
            r_dbz_out <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_DONE;
        end
        c_DONE: begin
          r_done  <= 1'b0;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_q_out;
  assign bus.remainder   = r_r_out;
  assign bus.div_by_zero = r_dbz_out;

endmodule

`default_nettype wire

// File: tb/tb_booth_divider_datapath.sv
// ============================================================================
// Module  : tb_booth_divider_datapath
// Purpose : Directed vector table plus corner sequences for the WIDTH=4 divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_divider_datapath;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  booth_divider_datapath_if #(.WIDTH(W)) bif ();

  booth_divider_datapath #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one op; returns busy right after the accepting edge, busy/latency at done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic busy_k, output logic busy_d, output int lat);
    @(negedge clk);
    bif.dividend = a;
    bif.divisor  = b;
    bif.start    = 1'b1;
    @(posedge clk);
    #1;
    bif.start = 1'b0;
    busy_k = bif.busy;
    lat = 0;
    while (!bif.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    busy_d = bif.busy;
  endtask

  logic busy_k, busy_d;
  int   lat;
  int   exp_lat;
  int   done_seen;

  initial begin
    checks     = 0;
    failures   = 0;
    bif.start    = 1'b0;
    bif.dividend = '0;
    bif.divisor  = '0;

`ifdef SIGNED_DIV_EN
    vecs[0]  = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0};
    vecs[1]  = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0};
    vecs[2]  = '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1};
    vecs[3]  = '{4'h6, 4'h3, 4'h2, 4'h0, 1'b0};
    vecs[4]  = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0};
    vecs[5]  = '{4'h7, 4'hE, 4'hD, 4'h1, 1'b0};
    vecs[6]  = '{4'h9, 4'hE, 4'h3, 4'hF, 1'b0};
    vecs[7]  = '{4'h8, 4'h3, 4'hE, 4'hE, 1'b0};
    vecs[8]  = '{4'h0, 4'h5, 4'h0, 4'h0, 1'b0};
    vecs[9]  = '{4'h8, 4'h0, 4'hF, 4'h8, 1'b1};
    vecs[10] = '{4'h5, 4'hF, 4'hB, 4'h0, 1'b0};
    vecs[11] = '{4'hF, 4'h7, 4'h0, 4'hF, 1'b0};
`else
    vecs[0]  = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0};
    vecs[1]  = '{4'h9, 4'h2, 4'h4, 4'h1, 1'b0};
    vecs[2]  = '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1};
    vecs[3]  = '{4'h6, 4'h3, 4'h2, 4'h0, 1'b0};
    vecs[4]  = '{4'h8, 4'hF, 4'h0, 4'h8, 1'b0};
    vecs[5]  = '{4'hF, 4'h4, 4'h3, 4'h3, 1'b0};
    vecs[6]  = '{4'hF, 4'h1, 4'hF, 4'h0, 1'b0};
    vecs[7]  = '{4'h0, 4'h5, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{4'hD, 4'hD, 4'h1, 4'h0, 1'b0};
    vecs[9]  = '{4'h8, 4'h0, 4'hF, 4'h8, 1'b1};
    vecs[10] = '{4'hE, 4'h3, 4'h4, 4'h2, 1'b0};
    vecs[11] = '{4'h1, 4'hF, 4'h0, 4'h1, 1'b0};
`endif

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bif.busy), 0);
    check("rst_done", int'(bif.done), 0);
    check("rst_q",    int'(bif.quotient), 0);
    check("rst_r",    int'(bif.remainder), 0);
    check("rst_dbz",  int'(bif.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, busy_k, busy_d, lat);
      exp_lat = vecs[i].z ? 1 : W + 1;
      check($sformatf("v%0d_busy_start", i), int'(busy_k), 1);
      check($sformatf("v%0d_latency", i), lat, exp_lat);
      check($sformatf("v%0d_busy_done", i), int'(busy_d), 0);
      check($sformatf("v%0d_q", i), int'(bif.quotient), int'(vecs[i].q));
      check($sformatf("v%0d_r", i), int'(bif.remainder), int'(vecs[i].r));
      check($sformatf("v%0d_dbz", i), int'(bif.div_by_zero), int'(vecs[i].z));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), int'(bif.done), 0);
      check($sformatf("v%0d_q_hold", i), int'(bif.quotient), int'(vecs[i].q));
    end

    // Start pulses during CALC and during DONE must be ignored.
    @(negedge clk);
    bif.dividend = 4'h7;
    bif.divisor  = 4'h2;
    bif.start    = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    bif.dividend = 4'hF;
    bif.divisor  = 4'h1;
    bif.start    = 1'b1;
    @(negedge clk);
    bif.start    = 1'b0;
    bif.dividend = 4'h3;
    bif.divisor  = 4'h3;
    lat = 0;
    while (!bif.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done_seen", int'(bif.done), 1);
    check("ign_q", int'(bif.quotient), 3);
    check("ign_r", int'(bif.remainder), 1);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    check("ign_done_start_busy", int'(bif.busy), 0);
    @(negedge clk);
    check("ign_idle_busy", int'(bif.busy), 0);
    check("ign_q_hold", int'(bif.quotient), 3);
    do_op(4'h6, 4'h3, busy_k, busy_d, lat);
    check("after_ign_busy", int'(busy_k), 1);
    check("after_ign_q", int'(bif.quotient), 2);
    check("after_ign_r", int'(bif.remainder), 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bif.dividend = 4'h7;
    bif.divisor  = 4'h2;
    bif.start    = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(bif.busy), 0);
    check("abort_q",    int'(bif.quotient), 0);
    check("abort_r",    int'(bif.remainder), 0);
    check("abort_dbz",  int'(bif.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (bif.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_idle_busy", int'(bif.busy), 0);
    do_op(4'hF, 4'h4, busy_k, busy_d, lat);
    check("fresh_latency", lat, W + 1);
`ifdef SIGNED_DIV_EN
    check("fresh_q", int'(bif.quotient), 0);
    check("fresh_r", int'(bif.remainder), 15);
`else
    check("fresh_q", int'(bif.quotient), 3);
    check("fresh_r", int'(bif.remainder), 3);
`endif
    check("fresh_dbz", int'(bif.div_by_zero), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
